// File: rtl/counting_gen_if.sv
// Command/stream bundle between a sequencing controller (master) and the
// counting_gen pattern generator (slave).
interface counting_gen_if #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
);
  logic             start;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic [1:0]       num;
  logic             valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sent_cnt;

  modport master (
    output start, reps, gap,
    input  num, valid, busy, done, sent_cnt
  );

  modport slave (
    input  start, reps, gap,
    output num, valid, busy, done, sent_cnt
  );
endinterface

// File: rtl/counting_gen.sv
// Emits the 01,10,11 pattern a programmed number of times with 00 filler gaps,
// then pulses done. Feeds the counting sequence detector.
//
//   state | meaning
//   IDLE  | waiting for start; outputs quiet
//   SYM1  | emitting 01
//   SYM2  | emitting 10
//   SYM3  | emitting 11; one repetition completes on exit
//   GAP   | emitting 00 filler between repetitions
//   DONE  | one-cycle completion pulse
module counting_gen #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  counting_gen_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SYM1, SYM2, SYM3, GAP, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] reps_q;
  logic [CNT_W-1:0] sent_q;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept;
  logic             last_rep;

  logic [1:0] num_d,  num_q;
  logic       valid_d, valid_q;
  logic       busy_d,  busy_q;
  logic       done_d,  done_q;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    num_d      = 2'b00;
    valid_d    = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    // CNT_W-bit compare; reps never exceeds 2^CNT_W-1 so sent_q+1 cannot wrap here
    last_rep   = ((sent_q + CNT_W'(1)) == reps_q);
    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          accept     = 1'b1;
          state_next = (bus.reps == '0) ? DONE : SYM1;
        end
      end
      SYM1: begin
        num_d      = 2'b01;
        valid_d    = 1'b1;
        state_next = SYM2;
      end
      SYM2: begin
        num_d      = 2'b10;
        valid_d    = 1'b1;
        state_next = SYM3;
      end
      SYM3: begin
        num_d   = 2'b11;
        valid_d = 1'b1;
        if (last_rep)           state_next = DONE;
        else if (gap_q == '0)   state_next = SYM1;
        else                    state_next = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1)) state_next = SYM1;
      end
      DONE: begin
        done_d     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are a registered decode of the current state, so every output
  // lags the state register by one cycle and has no path from the inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      reps_q  <= '0;
      gap_q   <= '0;
      sent_q  <= '0;
      gap_cnt <= '0;
      num_q   <= 2'b00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      num_q   <= num_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (accept) begin
        reps_q <= bus.reps;
        gap_q  <= bus.gap;
        sent_q <= '0;
      end
      if (state == SYM3) begin
        sent_q <= sent_q + CNT_W'(1);
        if (!last_rep) gap_cnt <= gap_q;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  assign bus.num      = num_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sent_cnt = sent_q;

endmodule

// File: tb/tb_counting_gen.sv
// Directed bench for counting_gen: checks the symbol stream, handshakes,
// sent_cnt and the number of detector matches for several commands.
module tb_counting_gen;
  localparam int CNT_W = 4;
  localparam int GAP_W = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counting_gen_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();
  counting_gen #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.reps  = '0;
    bus.gap   = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus.num !== 2'b00 || bus.valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.sent_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL reset: num=%0d valid=%0b busy=%0b done=%0b sent=%0d want all 0",
               bus.num, bus.valid, bus.busy, bus.done, bus.sent_cnt);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Issues one command and checks every cycle up to the return to idle.
  // disturb re-pulses start with different reps/gap while the run is active.
  task automatic test_pattern(input int r, input int g, input string tag, input bit disturb);
    int exp_num[$];
    int w, rep, ans, det, en, ev, eb, ed;
    for (int i = 0; i < r; i++) begin
      exp_num.push_back(1); exp_num.push_back(2); exp_num.push_back(3);
      if (i < r - 1) for (int j = 0; j < g; j++) exp_num.push_back(0);
    end
    w = exp_num.size();
    rep = 0; ans = 0; det = 0;
    bus.start = 1'b1;
    bus.reps  = CNT_W'(r);
    bus.gap   = GAP_W'(g);
    @(negedge clk);
    bus.start = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.sent_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL %s accept: busy=%0b sent=%0d want busy=0 sent=0", tag, bus.busy, bus.sent_cnt);
    end
    for (int k = 1; k <= w + 2; k++) begin
      if (disturb) begin
        bus.start = (k >= 2 && k <= 4);
        bus.reps  = CNT_W'(r + 5);
        bus.gap   = '0;
      end
      @(negedge clk);
      if (k <= w) begin
        en = exp_num[k-1]; ev = (en != 0); eb = 1; ed = 0;
      end else if (k == w + 1) begin
        en = 0; ev = 0; eb = 1; ed = 1;
      end else begin
        en = 0; ev = 0; eb = 0; ed = 0;
      end
      n_vec++;
      if (bus.num !== 2'(en) || bus.valid !== 1'(ev) || bus.busy !== 1'(eb) || bus.done !== 1'(ed)) begin
        n_bad++;
        $display("FAIL %s k=%0d: num=%0d valid=%0b busy=%0b done=%0b want num=%0d valid=%0d busy=%0d done=%0d",
                 tag, k, bus.num, bus.valid, bus.busy, bus.done, en, ev, eb, ed);
      end
      if (k <= w && en == 3) begin
        rep++;
        n_vec++;
        if (bus.sent_cnt !== CNT_W'(rep)) begin
          n_bad++;
          $display("FAIL %s sent_cnt k=%0d: got %0d want %0d", tag, k, bus.sent_cnt, rep);
        end
      end
      // detector model: 00 holds, 01->10->11 is a match
      if (bus.num == 2'b01) det = 1;
      else if (bus.num == 2'b10 && det == 1) det = 2;
      else if (bus.num == 2'b11 && det == 2) begin ans++; det = 0; end
      else if (bus.num != 2'b00) det = 0;
    end
    bus.start = 1'b0;
    n_vec++;
    if (bus.sent_cnt !== CNT_W'(r) || ans != r) begin
      n_bad++;
      $display("FAIL %s final: sent=%0d ans=%0d want %0d", tag, bus.sent_cnt, ans, r);
    end
  endtask

  task automatic test_single();     test_pattern(1, 3, "single_r1g3", 1'b0); endtask
  task automatic test_gapped();     test_pattern(3, 2, "multi_r3g2", 1'b0);  endtask
  task automatic test_no_gap();     test_pattern(2, 0, "nogap_r2g0", 1'b0);  endtask
  task automatic test_zero_reps();  test_pattern(0, 5, "zero_reps", 1'b0);   endtask
  task automatic test_ignore();     test_pattern(2, 1, "ignore_mid", 1'b1);  endtask
  task automatic test_max();        test_pattern(15, 7, "max_r15g7", 1'b0);  endtask

  // start held high: second command accepted in the IDLE cycle after DONE
  task automatic test_back_to_back();
    bus.start = 1'b1;
    bus.reps  = 4'd1;
    bus.gap   = 3'd0;
    @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) begin
        n_vec++;
        if (bus.done !== 1'b1 || bus.sent_cnt !== 4'd1) begin
          n_bad++;
          $display("FAIL b2b done: done=%0b sent=%0d want 1 1", bus.done, bus.sent_cnt);
        end
      end
      if (k == 5) begin
        n_vec++;
        if (bus.busy !== 1'b0 || bus.sent_cnt !== 4'd0) begin
          n_bad++;
          $display("FAIL b2b idle: busy=%0b sent=%0d want 0 0", bus.busy, bus.sent_cnt);
        end
      end
      if (k == 6) begin
        n_vec++;
        if (bus.num !== 2'b01 || bus.busy !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b restart: num=%0d busy=%0b want 1 1", bus.num, bus.busy);
        end
      end
    end
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.sent_cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL b2b drain: busy=%0b sent=%0d want 0 1", bus.busy, bus.sent_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    bus.start = 1'b1;
    bus.reps  = 4'd4;
    bus.gap   = 3'd1;
    @(negedge clk);
    bus.start = 1'b0;
    // outputs k=1..5: 01,10,11,00,01 ; state is in SYM2 of rep 2 now
    repeat (5) @(negedge clk);
    n_vec++;
    if (bus.num !== 2'b01 || bus.sent_cnt !== 4'd1) begin
      n_bad++;
      $display("FAIL rst_mid pre: num=%0d sent=%0d want 1 1", bus.num, bus.sent_cnt);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (bus.num !== 2'b00 || bus.busy !== 1'b0 || bus.sent_cnt !== 4'd0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid post: num=%0d busy=%0b sent=%0d done=%0b want 0 0 0 0",
               bus.num, bus.busy, bus.sent_cnt, bus.done);
    end
    seen_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
    end
    n_vec++;
    if (seen_done != 0) begin
      n_bad++;
      $display("FAIL rst_mid quiet: active cycles=%0d want 0", seen_done);
    end
    test_pattern(1, 0, "after_rst_r1", 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_gapped();
    test_no_gap();
    test_zero_reps();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_max();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
